// File: rtl/mem_burst_responder.sv
// rtl/mem_burst_responder.sv - burst read/write responder serving an on-chip word array
// Commands are accepted in IDLE or DONE; read beats are registered one cycle after each READ edge.
module mem_burst_responder #(
  parameter int MAIN_MEM_ADDR_WIDTH = 32,
  parameter int BURST_WIDTH         = 6,
  parameter int DATA_WIDTH          = 16,
  parameter int DEPTH               = 256
) (
  input  logic                           w_clock,
  input  logic                           w_rst_n,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr,
  input  logic                           w_rw,
  input  logic [BURST_WIDTH-1:0]         w_burst,
  input  logic [DATA_WIDTH-1:0]          w_wdata,
  input  logic                           w_wvalid,
  output logic [DATA_WIDTH-1:0]          w_rdata,
  output logic                           w_rvalid,
  output logic                           w_busy,
  output logic                           w_done,
  output logic                           w_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SUM_W = (BURST_WIDTH > IDX_W) ? BURST_WIDTH : IDX_W;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       base;
  logic [BURST_WIDTH-1:0] len;
  logic [BURST_WIDTH-1:0] cnt;
  logic [SUM_W-1:0]       sum;
  logic [IDX_W-1:0]       idx;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic cmd_present;
  logic addr_oob;
  logic at_last;
  logic accept;
  logic rd_beat;
  logic wr_beat;
  logic last_beat;
  logic cmd_collision;

  assign cmd_present = (w_burst != '0);
  assign addr_oob    = ((w_addr >> IDX_W) != '0);
  assign at_last     = (cnt == (len - BURST_WIDTH'(1)));

  // The sum is wide enough for either operand, so truncation gives the wrap modulo DEPTH.
  assign sum = SUM_W'(base) + SUM_W'(cnt);
  assign idx = sum[IDX_W-1:0];

  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    rd_beat       = 1'b0;
    wr_beat       = 1'b0;
    last_beat     = 1'b0;
    cmd_collision = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (cmd_present) begin
          accept    = 1'b1;
          state_nxt = w_rw ? READ : WRITE;
        end
      end
      READ: begin
        rd_beat       = 1'b1;
        last_beat     = at_last;
        cmd_collision = cmd_present;
        if (at_last) begin
          state_nxt = DONE;
        end
      end
      WRITE: begin
        cmd_collision = cmd_present;
        if (w_wvalid) begin
          wr_beat   = 1'b1;
          last_beat = at_last;
          if (at_last) begin
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      w_rdata  <= '0;
      w_rvalid <= 1'b0;
      w_busy   <= 1'b0;
      w_done   <= 1'b0;
      w_err    <= 1'b0;
      base     <= '0;
      len      <= '0;
      cnt      <= '0;
    end else begin
      w_rvalid <= rd_beat;
      w_done   <= last_beat;
      if (accept) begin
        base   <= w_addr[IDX_W-1:0];
        len    <= w_burst;
        cnt    <= '0;
        w_busy <= 1'b1;
      end else begin
        if (last_beat) begin
          w_busy <= 1'b0;
        end
        if (rd_beat || wr_beat) begin
          cnt <= cnt + BURST_WIDTH'(1);
        end
      end
      if (rd_beat) begin
        w_rdata <= mem[idx];
      end
      if ((accept && addr_oob) || cmd_collision) begin
        w_err <= 1'b1;
      end
    end
  end

  // Array is deliberately not reset; a reset edge suppresses any pending write beat.
  always_ff @(posedge w_clock) begin
    if (w_rst_n && wr_beat) begin
      mem[idx] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_mem_burst_responder.sv
// tb/tb_mem_burst_responder.sv - directed self-checking bench for mem_burst_responder
// Inputs change and outputs are sampled on the falling edge; a shadow array tracks written words.
module tb_mem_burst_responder;

  logic        w_clock;
  logic        w_rst_n;
  logic [31:0] w_addr;
  logic        w_rw;
  logic [5:0]  w_burst;
  logic [15:0] w_wdata;
  logic        w_wvalid;
  logic [15:0] w_rdata;
  logic        w_rvalid;
  logic        w_busy;
  logic        w_done;
  logic        w_err;

  logic [15:0] model [256];
  int n_checks = 0;
  int n_fail   = 0;

  mem_burst_responder #(
    .MAIN_MEM_ADDR_WIDTH(32),
    .BURST_WIDTH(6),
    .DATA_WIDTH(16),
    .DEPTH(256)
  ) dut (
    .w_clock (w_clock),
    .w_rst_n (w_rst_n),
    .w_addr  (w_addr),
    .w_rw    (w_rw),
    .w_burst (w_burst),
    .w_wdata (w_wdata),
    .w_wvalid(w_wvalid),
    .w_rdata (w_rdata),
    .w_rvalid(w_rvalid),
    .w_busy  (w_busy),
    .w_done  (w_done),
    .w_err   (w_err)
  );

  initial begin
    w_clock = 1'b0;
    forever #5 w_clock = ~w_clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic rw, input logic [5:0] b);
    w_addr  = a;
    w_rw    = rw;
    w_burst = b;
    @(negedge w_clock);
    w_burst = '0;
  endtask

  task automatic write_burst(input logic [31:0] a, input int n, input logic [15:0] seed,
                             input logic [15:0] step, input bit gap, input int rst_at);
    logic [15:0] d;
    issue(a, 1'b0, 6'(n));
    for (int k = 0; k < n; k++) begin
      d = seed + 16'(k) * step;
      if (gap && k == 1) begin
        w_wvalid = 1'b0;
        repeat (2) begin
          @(negedge w_clock);
          check("gap_busy", 32'(w_busy), 32'd1);
          check("gap_done", 32'(w_done), 32'd0);
        end
      end
      w_wvalid = 1'b1;
      w_wdata  = d;
      if (k == rst_at) begin
        w_rst_n = 1'b0;
        @(negedge w_clock);
        check("rst_rdata", 32'(w_rdata), 32'd0);
        check("rst_rvalid", 32'(w_rvalid), 32'd0);
        check("rst_busy", 32'(w_busy), 32'd0);
        check("rst_done", 32'(w_done), 32'd0);
        check("rst_err", 32'(w_err), 32'd0);
        w_rst_n  = 1'b1;
        w_wvalid = 1'b0;
        return;
      end
      @(negedge w_clock);
      model[8'(a + 32'(k))] = d;
      if (k < n - 1) begin
        check("wr_done_early", 32'(w_done), 32'd0);
      end
    end
    w_wvalid = 1'b0;
    check("wr_done", 32'(w_done), 32'd1);
    check("wr_busy_end", 32'(w_busy), 32'd0);
    @(negedge w_clock);
    check("wr_done_clear", 32'(w_done), 32'd0);
  endtask

  task automatic read_beats(input logic [31:0] a, input int n, input int inj);
    for (int k = 0; k < n; k++) begin
      if (k == inj) begin
        w_burst = 6'd2;
        w_rw    = 1'b0;
      end
      @(negedge w_clock);
      w_burst = '0;
      w_rw    = 1'b1;
      check("rd_valid", 32'(w_rvalid), 32'd1);
      check("rd_data", 32'(w_rdata), 32'(model[8'(a + 32'(k))]));
    end
    check("rd_done", 32'(w_done), 32'd1);
    check("rd_busy_end", 32'(w_busy), 32'd0);
  endtask

  task automatic read_burst(input logic [31:0] a, input int n, input int inj);
    issue(a, 1'b1, 6'(n));
    check("rd_latency", 32'(w_rvalid), 32'd0);
    check("rd_busy", 32'(w_busy), 32'd1);
    read_beats(a, n, inj);
    @(negedge w_clock);
    check("rd_valid_clear", 32'(w_rvalid), 32'd0);
    check("rd_done_clear", 32'(w_done), 32'd0);
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    repeat (2) @(negedge w_clock);
    w_rst_n = 1'b1;
  endtask

  initial begin
    w_rst_n  = 1'b0;
    w_addr   = '0;
    w_rw     = 1'b0;
    w_burst  = '0;
    w_wdata  = '0;
    w_wvalid = 1'b0;
    repeat (2) @(negedge w_clock);
    check("reset_rdata", 32'(w_rdata), 32'd0);
    check("reset_rvalid", 32'(w_rvalid), 32'd0);
    check("reset_busy", 32'(w_busy), 32'd0);
    check("reset_done", 32'(w_done), 32'd0);
    check("reset_err", 32'(w_err), 32'd0);
    w_rst_n = 1'b1;
    @(negedge w_clock);

    // Preload, including a write that wraps 254 -> 3.
    write_burst(32'd4, 4, 16'h00A0, 16'h0001, 1'b0, -1);
    write_burst(32'd254, 6, 16'hB000, 16'h0101, 1'b0, -1);
    write_burst(32'd13, 1, 16'h5555, 16'h0000, 1'b0, -1);

    // Basic read of A0..A3 with hand values.
    issue(32'd4, 1'b1, 6'd4);
    check("basic_latency", 32'(w_rvalid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge w_clock);
      check("basic_valid", 32'(w_rvalid), 32'd1);
      check("basic_data", 32'(w_rdata), 32'h00A0 + 32'(k));
    end
    check("basic_done", 32'(w_done), 32'd1);
    check("basic_busy", 32'(w_busy), 32'd0);
    @(negedge w_clock);
    check("basic_after_valid", 32'(w_rvalid), 32'd0);
    check("basic_hold_data", 32'(w_rdata), 32'h00A3);

    // Gapped write then read back; mem[13] must keep 0x5555.
    write_burst(32'd10, 3, 16'h0011, 16'h0011, 1'b1, -1);
    issue(32'd10, 1'b1, 6'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge w_clock);
      check("gapwr_data", 32'(w_rdata), (k == 3) ? 32'h5555 : 32'h11 * 32'(k + 1));
    end
    @(negedge w_clock);

    // Wrap read: 254,255,0,1 = B000,B101,B202,B303.
    issue(32'd254, 1'b1, 6'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge w_clock);
      check("wrap_data", 32'(w_rdata), 32'hB000 + 32'h0101 * 32'(k));
    end
    @(negedge w_clock);
    check("wrap_err", 32'(w_err), 32'd0);

    // Out-of-range address truncates to index 3 (B505) and flags an error.
    read_burst(32'h0000_0103, 1, -1);
    check("oob_data", 32'(w_rdata), 32'hB505);
    check("oob_err", 32'(w_err), 32'd1);
    do_reset();
    check("err_cleared", 32'(w_err), 32'd0);

    // Colliding command at beat 2 of a 5-beat read.
    read_burst(32'd3, 5, 2);
    check("collide_err", 32'(w_err), 32'd1);
    do_reset();

    // Reset at write beat 2 of 6: only beats 0-1 land.
    write_burst(32'd20, 6, 16'h7700, 16'h0001, 1'b0, -1);
    write_burst(32'd20, 6, 16'hC000, 16'h0001, 1'b0, 2);
    issue(32'd20, 1'b1, 6'd6);
    for (int k = 0; k < 6; k++) begin
      @(negedge w_clock);
      check("rstwr_data", 32'(w_rdata), (k < 2) ? 32'hC000 + 32'(k) : 32'h7700 + 32'(k));
    end
    @(negedge w_clock);
    read_burst(32'd20, 6, -1);

    // Max-length read with a command queued during DONE.
    write_burst(32'd100, 63, 16'h1000, 16'h0003, 1'b0, -1);
    issue(32'd100, 1'b1, 6'd63);
    read_beats(32'd100, 63, -1);
    w_addr  = 32'd4;
    w_rw    = 1'b1;
    w_burst = 6'd4;
    @(negedge w_clock);
    w_burst = '0;
    check("b2b_bubble", 32'(w_rvalid), 32'd0);
    check("b2b_busy", 32'(w_busy), 32'd1);
    read_beats(32'd4, 4, -1);
    @(negedge w_clock);
    check("b2b_err", 32'(w_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
